// File: rtl/pipe_hazard_ctrl.sv
// Hazard and flush controller for a 5-stage pipeline without forwarding.
// A 3-entry destination-tag scoreboard shadows EX/MEM/WB. While a decoded
// source register still has a write in flight, PC and IF/ID are held and
// ID/EX gets bubbles. A taken branch in EX flushes the wrong-path fetch
// plus ROM_LATENCY extra cycles to drain the registered ROM output.
module pipe_hazard_ctrl #(
  parameter int WB_BYPASS   = 0,   // 1: regfile written in first half-cycle
  parameter int R0_IS_ZERO  = 0,   // 1: r0 never creates a dependency
  parameter int ROM_LATENCY = 1,   // extra flush cycles after a taken branch
  parameter int STALL_CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,           // async, active-low
  input  logic                   id_valid,
  input  logic [4:0]             id_rn,
  input  logic [4:0]             id_rm,
  input  logic                   id_uses_rn,
  input  logic                   id_uses_rm,
  input  logic [4:0]             id_rd,
  input  logic                   id_reg_write,
  input  logic                   ex_branch_taken,
  output logic                   pc_hold,
  output logic                   if_id_hold,
  output logic                   id_ex_bubble,
  output logic                   if_id_flush,
  output logic [1:0]             state,
  output logic [STALL_CNT_W-1:0] stall_cnt,
  output logic [15:0]            flush_cnt
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
  } tag_t;

  localparam logic [1:0] FC_LOAD = 2'(ROM_LATENCY);

  state_e                 state_q, state_d;
  logic [1:0]             fc_q, fc_d;
  tag_t                   ex_q, ex_d;
  tag_t                   mem_q, mem_d;
  tag_t                   wb_q, wb_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [15:0]            flush_cnt_q, flush_cnt_d;

  logic in_flush;
  logic eff_valid;
  logic match_rn;
  logic match_rm;
  logic hazard;
  logic issue;

  // True when a write to r is still ahead of the register file.
  function automatic logic tag_match(input tag_t ex, input tag_t mem,
                                     input tag_t wb, input logic [4:0] r);
    logic hit;
    hit = (ex.v && ex.rd == r) || (mem.v && mem.rd == r) ||
          ((WB_BYPASS == 0) && wb.v && wb.rd == r);
    if ((R0_IS_ZERO != 0) && r == 5'd0) hit = 1'b0;
    return hit;
  endfunction

  // Hazard detection and pipeline control outputs.
  always_comb begin
    in_flush     = (state_q == ST_FLUSH);
    eff_valid    = id_valid && !in_flush;
    match_rn     = tag_match(ex_q, mem_q, wb_q, id_rn);
    match_rm     = tag_match(ex_q, mem_q, wb_q, id_rm);
    // A register used on both rn and rm is simply an OR: counted once.
    hazard       = eff_valid && ((id_uses_rn && match_rn) ||
                                 (id_uses_rm && match_rm));
    // A taken branch wins: PC must not be held so it can load the target.
    issue        = eff_valid && !hazard && !ex_branch_taken;
    pc_hold      = hazard && !ex_branch_taken;
    if_id_hold   = pc_hold;
    id_ex_bubble = hazard || ex_branch_taken || in_flush;
    if_id_flush  = ex_branch_taken || in_flush;
  end

  // Scoreboard shift: a tag advances one stage per cycle, new tag on issue.
  always_comb begin
    wb_d     = mem_q;
    mem_d    = ex_q;
    ex_d.v   = issue && id_reg_write;
    ex_d.rd  = id_rd;
  end

  // Next-state logic for RUN/STALL/FLUSH and the flush down-counter.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the case leaves it unassigned, which would infer a latch.
    state_d = state_q;
    fc_d    = fc_q;
    unique case (state_q)
      ST_RUN, ST_STALL: begin
        if (ex_branch_taken) begin
          if (ROM_LATENCY == 0) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_FLUSH;
            fc_d    = FC_LOAD;
          end
        end else if (hazard) begin
          state_d = ST_STALL;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_FLUSH: begin
        if (ex_branch_taken) begin
          // Back-to-back branch restarts the drain window.
          state_d = (ROM_LATENCY == 0) ? ST_RUN : ST_FLUSH;
          fc_d    = FC_LOAD;
        end else if (fc_q <= 2'd1) begin
          state_d = ST_RUN;
          fc_d    = 2'd0;
        end else begin
          fc_d    = fc_q - 2'd1;
        end
      end
      default: begin
        state_d = ST_RUN;
        fc_d    = 2'd0;
      end
    endcase
  end

  // Performance counters: stalls saturate, flushes wrap.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (pc_hold && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
    flush_cnt_d = flush_cnt_q;
    if (ex_branch_taken) flush_cnt_d = flush_cnt_q + 16'd1;
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!rst) begin
      state_q     <= ST_RUN;
      fc_q        <= 2'd0;
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      fc_q        <= fc_d;
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      wb_q        <= wb_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign state     = state_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Sequences the 5-stage pipeline (IF/ID/EX/MEM/WB). It has no forwarding paths and a registered-output instruction ROM.
- A 3-entry destination-tag scoreboard mirrors the EX, MEM and WB stages. It holds PC and IF/ID, and injects bubbles into ID/EX, while a decoded source register still has a write in flight.
- Flushes wrong-path instructions when a branch resolves taken in EX.
- Sits beside the decoder and Control_Unit; drives hold/flush inputs of pc, Pipeline_IF_ID and Pipeline_ID_EX.

Parameters:
- WB_BYPASS, 0: 1 = register file writes in first half-cycle, so the WB entry is excluded from the hazard check.
- R0_IS_ZERO, 0: 1 = register 0 is never a hazard source.
- ROM_LATENCY, 1: extra flush cycles after a taken branch to drop the stale ROM output (0..3).
- STALL_CNT_W, 32: width of the stall performance counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-low (0 = reset).
- id_valid  in  1  ID stage holds a real instruction.
- id_rn  in  5  first source register.
- id_rm  in  5  second source register.
- id_uses_rn  in  1  instruction reads rn.
- id_uses_rm  in  1  instruction reads rm.
- id_rd  in  5  destination register.
- id_reg_write  in  1  instruction writes rd.
- ex_branch_taken  in  1  branch in EX resolved taken; PC target is valid this cycle.
- pc_hold  out  1  PC keeps its value.
- if_id_hold  out  1  IF/ID register keeps its value.
- id_ex_bubble  out  1  ID/EX loads a NOP (reg_write=0, mem_write=0).
- if_id_flush  out  1  IF/ID loads a NOP.
- state  out  2  0=RUN, 1=STALL, 2=FLUSH.
- stall_cnt  out  STALL_CNT_W  total stall cycles, saturating.
- flush_cnt  out  16  taken-branch flushes, wrapping.

Behaviour:
- Scoreboard: three entries ex_t, mem_t, wb_t, each {v, rd}.
  - Every cycle: wb_t <= mem_t; mem_t <= ex_t.
  - ex_t <= {issue & id_reg_write, id_rd} where issue = eff_valid & ~hazard & ~ex_branch_taken.
  - Otherwise ex_t.v <= 0.
- eff_valid = id_valid & (state != FLUSH).
- match(r): any of ex_t/mem_t (and wb_t if WB_BYPASS=0) has v=1 and rd==r. Forced 0 when R0_IS_ZERO=1 and r==0.
- hazard = eff_valid & ((id_uses_rn & match(id_rn)) | (id_uses_rm & match(id_rm))).
- Outputs are combinational from registered state and current inputs:
  - pc_hold = if_id_hold = hazard & ~ex_branch_taken.
  - id_ex_bubble = hazard | ex_branch_taken | (state==FLUSH).
  - if_id_flush = ex_branch_taken | (state==FLUSH).
- Branch priority: ex_branch_taken overrides hazard. PC is not held, so it loads the target.
- FSM:
  - RUN: on ex_branch_taken go to FLUSH with flush counter fc=ROM_LATENCY; if ROM_LATENCY=0, stay RUN. Else on hazard go to STALL.
  - STALL: on ex_branch_taken go to FLUSH. On ~hazard go to RUN. Stall length is inherent: 3 cycles after a dependent producer (2 with WB_BYPASS=1).
  - FLUSH: fc decrements each cycle; go to RUN when fc reaches 1. A new ex_branch_taken reloads fc and increments flush_cnt.
- Counters:
  - stall_cnt += 1 on each cycle with pc_hold=1; saturates at all-ones.
  - flush_cnt += 1 on each ex_branch_taken cycle; wraps.
- Reset (rst=0, asynchronous, usable mid-operation):
  - all tag v=0, state=RUN, fc=0, stall_cnt=0, flush_cnt=0.
  - Hence pc_hold=if_id_hold=0, and id_ex_bubble=if_id_flush=0 while ex_branch_taken=0.
- Back-to-back independent instructions never stall. Producer with id_reg_write=0 never creates a tag.
- Same register on rn and rm counts once; stall length is unchanged.

Test Plan:
- Release reset, issue I1 (rd=3, reg_write=1), then I2 (rn=3, uses_rn=1) next cycle.
  - Required: pc_hold=1 and id_ex_bubble=1 for exactly 3 cycles, I2 issues on cycle 4, stall_cnt=3, state RUN→STALL→RUN.
- Same sequence with WB_BYPASS=1 → exactly 2 stall cycles, stall_cnt=2.
- I1 reg_write=0 (rd=3), I2 reads r3 → no hold, no bubble, stall_cnt=0.
  - With R0_IS_ZERO=1: I1 writes r0, I2 reads r0 → no stall.
- During a hazard stall, pulse ex_branch_taken for 1 cycle (ROM_LATENCY=1).
  - That cycle: pc_hold=0, if_id_flush=1, id_ex_bubble=1.
  - Next cycle: state=FLUSH with if_id_flush=1, then RUN. flush_cnt=1, ex_t.v=0.
- Two taken branches 1 cycle apart with ROM_LATENCY=2 → FLUSH extended (fc reloaded), flush_cnt=2, no issue until 2 cycles after the second branch.
- Assert rst=0 mid-stall (asynchronously, between clock edges).
  - Immediately: pc_hold=0, state=RUN, stall_cnt=0.
  - After release, a dependent read of the old rd does not stall.
